// File: rtl/ecp5_pll_pkg.sv
// rtl/ecp5_pll_pkg.sv - shared types and constants for the EHXPLLL phase-shift sequencer
package ecp5_pll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int   PHASESEL_W = 2;
    localparam logic DIR_LAG    = 1'b0;
    localparam logic DIR_LEAD   = 1'b1;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ecp5_pll_phase_ctrl.sv
// rtl/ecp5_pll_phase_ctrl.sv - EHXPLLL dynamic phase-shift sequencer; PHASE_TRACK_EN adds per-channel phase accumulators
module ecp5_pll_phase_ctrl
    import ecp5_pll_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int STEP_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  pll_lock_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [PHASESEL_W-1:0] req_chan_i,
    input  logic                  req_dir_i,
    input  logic [STEP_W-1:0]     req_steps_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [PHASESEL_W-1:0] phasesel_o,
    output logic                  phasedir_o,
    output logic                  phasestep_o,
    output logic                  locked_o
`ifdef PHASE_TRACK_EN
    ,
    output logic [N_CH*(STEP_W+2)-1:0] phase_acc_o
`endif
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                             ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [STEP_W-1:0]       rem_q, rem_d;
    logic [PHASESEL_W-1:0]   sel_q;
    logic                    dir_q;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    accept, load, tmr_zero;

    sync2 u_lock_sync (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .d     (pll_lock_i),
        .q     (locked_o)
    );

    assign req_ready_o = (state_q == ST_IDLE) && locked_o;
    assign accept      = req_valid_i && req_ready_o;
    assign tmr_zero    = (tmr_q == '0);
    // Gating with locked_o releases PHASESTEP in the very cycle lock is seen lost.
    assign phasestep_o = !((state_q == ST_PULSE) && locked_o);
    assign phasesel_o  = sel_q;
    assign phasedir_o  = dir_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (int'(req_chan_i) >= N_CH) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (req_steps_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        tmr_d   = TMR_W'(SETUP_CYC - 1);
                        rem_d   = req_steps_i;
                    end
                end
            end
            ST_SETUP, ST_PULSE, ST_GAP: begin
                if (!locked_o) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (!tmr_zero) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (state_q == ST_SETUP) begin
                    state_d = ST_PULSE;
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                end else if (state_q == ST_PULSE) begin
                    state_d = ST_GAP;
                    tmr_d   = TMR_W'(GAP_CYC - 1);
                    rem_d   = rem_q - STEP_W'(1);
                end else if (rem_q != '0) begin
                    state_d = ST_PULSE;
                    tmr_d   = TMR_W'(PULSE_CYC - 1);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (load) begin
                sel_q <= req_chan_i;
                dir_q <= req_dir_i;
            end
        end
    end

`ifdef PHASE_TRACK_EN
    localparam int ACC_W = STEP_W + 2;

    logic [ACC_W-1:0] acc_q [N_CH];
    logic             pulse_exit;

    // Only completed pulses count; a pulse cut short by lock loss is not recorded.
    assign pulse_exit = (state_q == ST_PULSE) && locked_o && tmr_zero;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
        end else if (pulse_exit) begin
            for (int i = 0; i < N_CH; i++) begin
                if (sel_q == PHASESEL_W'(i))
                    acc_q[i] <= acc_q[i] + ((dir_q == DIR_LEAD) ? ACC_W'(1) : {ACC_W{1'b1}});
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_acc
        assign phase_acc_o[g*ACC_W +: ACC_W] = acc_q[g];
    end
`endif

endmodule
